// File: rtl/axi_slave_mem.sv
// AXI4 responder in front of a simple SRAM: one outstanding write and one outstanding read,
// with independent write (W_IDLE/W_DATA/W_RESP) and read (R_IDLE/R_REQ/R_DATA) engines.
module axi_slave_mem #(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 1,
  parameter int MEM_ADDR_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [AXI_ID_WIDTH-1:0]     axi_aw_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr_i,
  input  logic [7:0]                  axi_aw_len_i,
  input  logic [2:0]                  axi_aw_size_i,
  input  logic [1:0]                  axi_aw_burst_i,
  input  logic                        axi_aw_lock_i,
  input  logic [3:0]                  axi_aw_cache_i,
  input  logic [2:0]                  axi_aw_prot_i,
  input  logic [3:0]                  axi_aw_qos_i,
  input  logic [3:0]                  axi_aw_region_i,
  input  logic [AXI_USER_WIDTH-1:0]   axi_aw_user_i,
  input  logic                        axi_aw_valid_i,
  output logic                        axi_aw_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_w_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] axi_w_strb_i,
  input  logic                        axi_w_last_i,
  input  logic [AXI_USER_WIDTH-1:0]   axi_w_user_i,
  input  logic                        axi_w_valid_i,
  output logic                        axi_w_ready_o,
  output logic [AXI_ID_WIDTH-1:0]     axi_b_id_o,
  output logic [1:0]                  axi_b_resp_o,
  output logic [AXI_USER_WIDTH-1:0]   axi_b_user_o,
  output logic                        axi_b_valid_o,
  input  logic                        axi_b_ready_i,
  input  logic [AXI_ID_WIDTH-1:0]     axi_ar_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_ar_addr_i,
  input  logic [7:0]                  axi_ar_len_i,
  input  logic [2:0]                  axi_ar_size_i,
  input  logic [1:0]                  axi_ar_burst_i,
  input  logic                        axi_ar_lock_i,
  input  logic [3:0]                  axi_ar_cache_i,
  input  logic [2:0]                  axi_ar_prot_i,
  input  logic [3:0]                  axi_ar_qos_i,
  input  logic [3:0]                  axi_ar_region_i,
  input  logic [AXI_USER_WIDTH-1:0]   axi_ar_user_i,
  input  logic                        axi_ar_valid_i,
  output logic                        axi_ar_ready_o,
  output logic [AXI_ID_WIDTH-1:0]     axi_r_id_o,
  output logic [AXI_DATA_WIDTH-1:0]   axi_r_data_o,
  output logic [1:0]                  axi_r_resp_o,
  output logic                        axi_r_last_o,
  output logic [AXI_USER_WIDTH-1:0]   axi_r_user_o,
  output logic                        axi_r_valid_o,
  input  logic                        axi_r_ready_i,
  output logic                        mem_wen_o,
  output logic [MEM_ADDR_WIDTH-1:0]   mem_waddr_o,
  output logic [AXI_DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [AXI_DATA_WIDTH/8-1:0] mem_wmask_o,
  output logic                        mem_ren_o,
  output logic [MEM_ADDR_WIDTH-1:0]   mem_raddr_o,
  input  logic [AXI_DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int BYTES = AXI_DATA_WIDTH / 8;
  localparam int OFFS  = $clog2(BYTES);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_DATA} r_state_t;

  function automatic logic [AXI_ADDR_WIDTH-1:0] next_addr(input logic [AXI_ADDR_WIDTH-1:0] addr,
                                                          input logic [2:0] size,
                                                          input logic [1:0] burst);
    return (burst == 2'b00) ? addr : addr + (AXI_ADDR_WIDTH'(1) << size);
  endfunction

  // WRAP and reserved bursts run as INCR but are flagged, as are beats wider than the bus
  function automatic logic bad_xfer(input logic [2:0] size, input logic [1:0] burst);
    return burst[1] || ((int'(1) << size) > BYTES);
  endfunction

  // ---------------- write path ----------------
  w_state_t                    w_state, w_state_nxt;
  logic [AXI_ID_WIDTH-1:0]     w_id;
  logic [AXI_ADDR_WIDTH-1:0]   w_addr;
  logic [7:0]                  w_len, w_beat;
  logic [2:0]                  w_size;
  logic [1:0]                  w_burst;
  logic                        w_len_err;
  logic                        aw_hs, w_hs;

  assign aw_hs = axi_aw_valid_i && axi_aw_ready_o;
  assign w_hs  = axi_w_valid_i && axi_w_ready_o;

  always_comb begin
    w_state_nxt    = w_state;
    axi_aw_ready_o = 1'b0;
    axi_w_ready_o  = 1'b0;
    axi_b_valid_o  = 1'b0;
    mem_wen_o      = 1'b0;
    case (w_state)
      W_IDLE: begin
        axi_aw_ready_o = rst_n;
        if (aw_hs) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        axi_w_ready_o = 1'b1;
        mem_wen_o     = axi_w_valid_i;
        if (w_hs && axi_w_last_i) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        axi_b_valid_o = 1'b1;
        if (axi_b_ready_i) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state   <= W_IDLE;
      w_id      <= '0;
      w_addr    <= '0;
      w_len     <= '0;
      w_beat    <= '0;
      w_size    <= '0;
      w_burst   <= '0;
      w_len_err <= 1'b0;
    end else begin
      w_state <= w_state_nxt;
      if (aw_hs) begin
        w_id      <= axi_aw_id_i;
        w_addr    <= axi_aw_addr_i;
        w_len     <= axi_aw_len_i;
        w_size    <= axi_aw_size_i;
        w_burst   <= axi_aw_burst_i;
        w_beat    <= '0;
        w_len_err <= 1'b0;
      end
      if (w_hs) begin
        w_addr <= next_addr(w_addr, w_size, w_burst);
        w_beat <= w_beat + 8'd1;
        // sticky: early last, or beat len passing without last
        if ((axi_w_last_i && w_beat != w_len) || (!axi_w_last_i && w_beat == w_len))
          w_len_err <= 1'b1;
      end
    end
  end

  assign mem_waddr_o  = w_addr[OFFS +: MEM_ADDR_WIDTH];
  assign mem_wdata_o  = axi_w_data_i;
  assign mem_wmask_o  = axi_w_strb_i;
  assign axi_b_id_o   = w_id;
  assign axi_b_resp_o = (bad_xfer(w_size, w_burst) || w_len_err) ? 2'b10 : 2'b00;
  assign axi_b_user_o = '0;

  // ---------------- read path ----------------
  r_state_t                    r_state, r_state_nxt;
  logic [AXI_ID_WIDTH-1:0]     r_id;
  logic [AXI_ADDR_WIDTH-1:0]   r_addr;
  logic [7:0]                  r_len, r_beat;
  logic [2:0]                  r_size;
  logic [1:0]                  r_burst;
  logic [AXI_DATA_WIDTH-1:0]   r_data_q;
  logic                        r_fresh;
  logic                        ar_hs, r_hs, r_is_last;

  assign ar_hs     = axi_ar_valid_i && axi_ar_ready_o;
  assign r_hs      = axi_r_valid_o && axi_r_ready_i;
  assign r_is_last = (r_beat == r_len);

  always_comb begin
    r_state_nxt    = r_state;
    axi_ar_ready_o = 1'b0;
    axi_r_valid_o  = 1'b0;
    mem_ren_o      = 1'b0;
    case (r_state)
      R_IDLE: begin
        axi_ar_ready_o = rst_n;
        if (ar_hs) r_state_nxt = R_REQ;
      end
      R_REQ: begin
        mem_ren_o   = 1'b1;
        r_state_nxt = R_DATA;
      end
      R_DATA: begin
        axi_r_valid_o = 1'b1;
        if (axi_r_ready_i) r_state_nxt = r_is_last ? R_IDLE : R_REQ;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= R_IDLE;
      r_id     <= '0;
      r_addr   <= '0;
      r_len    <= '0;
      r_beat   <= '0;
      r_size   <= '0;
      r_burst  <= '0;
      r_data_q <= '0;
      r_fresh  <= 1'b0;
    end else begin
      r_state <= r_state_nxt;
      r_fresh <= (r_state == R_REQ);
      if (r_fresh) r_data_q <= mem_rdata_i;
      if (ar_hs) begin
        r_id    <= axi_ar_id_i;
        r_addr  <= axi_ar_addr_i;
        r_len   <= axi_ar_len_i;
        r_size  <= axi_ar_size_i;
        r_burst <= axi_ar_burst_i;
        r_beat  <= '0;
      end
      if (r_hs && !r_is_last) begin
        r_addr <= next_addr(r_addr, r_size, r_burst);
        r_beat <= r_beat + 8'd1;
      end
    end
  end

  // memory data is only guaranteed in the cycle after the request; bypass it then, hold after
  assign axi_r_data_o = r_fresh ? mem_rdata_i : r_data_q;
  assign mem_raddr_o  = r_addr[OFFS +: MEM_ADDR_WIDTH];
  assign axi_r_id_o   = r_id;
  assign axi_r_resp_o = bad_xfer(r_size, r_burst) ? 2'b10 : 2'b00;
  assign axi_r_last_o = (r_state == R_DATA) && r_is_last;
  assign axi_r_user_o = '0;

  logic unused;
  assign unused = ^{axi_aw_lock_i, axi_aw_cache_i, axi_aw_prot_i, axi_aw_qos_i, axi_aw_region_i,
                    axi_aw_user_i, axi_w_user_i, axi_ar_lock_i, axi_ar_cache_i, axi_ar_prot_i,
                    axi_ar_qos_i, axi_ar_region_i, axi_ar_user_i, w_addr, r_addr};

endmodule

// File: doc/axi_slave_mem.md
AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- AXI_DATA_WIDTH, 64, data bus width in bits.
- AXI_ADDR_WIDTH, 64, AXI address width in bits.
- AXI_ID_WIDTH, 4, transaction ID width.
- AXI_USER_WIDTH, 1, user signal width.
- MEM_ADDR_WIDTH, 16, word address width of the memory.

REQ-002 Ports SHALL be, as name, direction, width, meaning (clock and reset first). The block has one clock, clk. Reset is rst_n: asynchronous, active-low.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- axi_aw_id_i/addr_i/len_i/size_i/burst_i  in  ID/ADDR/8/3/2  write address fields.
- axi_aw_valid_i  in  1;  axi_aw_ready_o  out  1.
- axi_w_data_i/strb_i/last_i  in  DATA/DATA/8/1  write data.
- axi_w_valid_i  in  1;  axi_w_ready_o  out  1.
- axi_b_id_o/resp_o/user_o  out  ID/2/USER;  axi_b_valid_o  out  1;  axi_b_ready_i  in  1.
- axi_ar_id_i/addr_i/len_i/size_i/burst_i  in  ID/ADDR/8/3/2;  axi_ar_valid_i  in  1;  axi_ar_ready_o  out  1.
- axi_r_id_o/data_o/resp_o/last_o/user_o  out  ID/DATA/2/1/USER;  axi_r_valid_o  out  1;  axi_r_ready_i  in  1.
- aw/ar lock, cache, prot, qos, region, user, and w_user  in  per AXI4  accepted and ignored.
- mem_wen_o  out  1  memory write strobe.
- mem_waddr_o  out  MEM_ADDR_WIDTH  memory write word address.
- mem_wdata_o  out  DATA  memory write data.
- mem_wmask_o  out  DATA/8  memory byte enables.
- mem_ren_o  out  1  memory read strobe.
- mem_raddr_o  out  MEM_ADDR_WIDTH  memory read word address.
- mem_rdata_i  in  DATA  read data, valid exactly 1 cycle after mem_ren_o.

Function
REQ-003 The block SHALL be an AXI4 responder. It SHALL hold one outstanding write and one outstanding read. The write and read paths SHALL be fully independent.

REQ-004 The word address SHALL be byte_addr >> log2(AXI_DATA_WIDTH/8), truncated to MEM_ADDR_WIDTH.

REQ-005 Write FSM states SHALL be W_IDLE, W_DATA and W_RESP:
- W_IDLE: axi_aw_ready_o=1. An aw handshake latches id, addr, len, size and burst, clears beat_cnt, and goes to W_DATA.
- W_DATA: axi_w_ready_o=1. Each w handshake drives mem_wen_o=1 combinationally with the current word address, w_data and w_strb. It then advances the address and increments beat_cnt.
- W_DATA exits to W_RESP on the handshake with w_last=1.
- W_RESP: axi_b_valid_o=1 with the latched id. Returns to W_IDLE on b_ready.

REQ-006 Read FSM states SHALL be R_IDLE, R_REQ and R_DATA:
- R_IDLE: axi_ar_ready_o=1. An ar handshake latches the fields and goes to R_REQ.
- R_REQ: mem_ren_o=1 for one cycle, then R_DATA. The cycle after R_REQ, mem_rdata_i SHALL be captured into the r_data register.
- R_DATA: axi_r_valid_o=1, axi_r_data_o is held stable, and axi_r_last_o=(beat_cnt==len).
- An r handshake on the last beat goes to R_IDLE. Any other r handshake advances the address, increments beat_cnt and goes to R_REQ.

REQ-007 Throughput SHALL be one read beat per 2 cycles with no backpressure. The first r_valid SHALL rise 2 cycles after the ar handshake.

REQ-008 Address advance SHALL follow the latched burst type:
- FIXED (00): the address stays constant.
- INCR (01): byte address += 1<<size.
- WRAP (10) or reserved (11): the burst is handled as INCR and the response is SLVERR.

REQ-009 The response SHALL be SLVERR (2'b10) if any of these holds, otherwise OKAY (2'b00):
- 1<<size exceeds AXI_DATA_WIDTH/8;
- the burst type is WRAP or reserved;
- (write only) w_last does not arrive exactly on beat len.

REQ-010 Early or missing w_last SHALL be handled as follows:
- If w_last arrives before beat len, the burst ends there.
- If beat len passes without w_last, further beats are written but the response is SLVERR.

REQ-011 axi_b_user_o and axi_r_user_o SHALL be 0.

REQ-012 Valid and data SHALL NOT change while valid=1 and ready=0.

REQ-013 A simultaneous read and write to the same word SHALL return whatever the memory returns. No ordering is enforced between the paths.

REQ-014 beat_cnt SHALL be 8 bits and SHALL NOT overflow for len ≤ 255.

Reset
REQ-015 On rst_n low, both FSMs SHALL go to idle. All valid outputs, mem_wen_o, mem_ren_o, axi_r_last_o and all counters SHALL be 0. All latched fields SHALL be 0.

REQ-016 While rst_n is low, axi_aw_ready_o and axi_ar_ready_o SHALL be 0. They SHALL rise in the first cycle after rst_n is released.

REQ-017 A reset mid-burst SHALL abort the burst with no further memory access and no B or R response.

Verification
REQ-018 Write INCR: aw addr 0x100, len 3, size 3, strb 0xFF. Required response: mem_waddr_o = 0x20,0x21,0x22,0x23; b_resp 00; b_id matches aw_id.

REQ-019 Read INCR: ar addr 0x100, len 3 over preloaded memory. Required response: 4 beats of the correct data; r_last only on the 4th beat; first r_valid 2 cycles after ar_hs.

REQ-020 Backpressure: r_ready low for 5 cycles mid-burst. Required response: r_data, r_valid and r_last stable throughout; no extra mem_ren_o.

REQ-021 Errors:
- aw len 2 with w_last on beat 1 → burst ends; b_resp 10.
- ar burst 2'b10 → r_resp 10 on every beat.

REQ-022 Concurrent traffic: a write burst len 7 and a read burst len 7 issued in the same cycle. Required response: both complete; the B response and the 8 R beats carry the correct ids.

REQ-023 Reset during W_DATA beat 2. Required response: mem_wen_o 0 immediately; no B response; aw_ready 1 in the first cycle after rst_n is released.
